// File: rtl/cam_pack_pkg.sv
// Shared constants and helpers for the camera-switch HDMI pack path.
// The pack bus is {clk, hsync, vsync, de, r, g, b, x, y}.
package cam_pack_pkg;

   localparam int PIX_W  = 24;
   localparam int CTRL_W = 4;

   function automatic int pack_w(input int h_act, input int v_act);
      return CTRL_W + PIX_W + $clog2(h_act) + $clog2(v_act);
   endfunction

endpackage

// File: rtl/line_fifo.sv
// Single-clock first-word-fall-through line FIFO with a synchronous flush.
// Flush wins over any write or read in the same cycle.
module line_fifo
   import cam_pack_pkg::*;
#(
   parameter int DEPTH = 2048,
   parameter int W     = PIX_W,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         wr_i,
   input  logic [W-1:0] wdata_i,
   input  logic         rd_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   count_q, count_d;
   logic          doWrite;
   logic          doRead;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rdPtr_q];

   assign doWrite = wr_i & ~full_o & ~flush_i;
   assign doRead  = rd_i & ~empty_o & ~flush_i;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (doWrite) wrPtr_d = wrPtr_q + 1'b1;
         if (doRead)  rdPtr_d = rdPtr_q + 1'b1;
         case ({doWrite, doRead})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (doWrite) mem_q[wrPtr_q] <= wdata_i;
   end

endmodule

// File: rtl/cam_pack_mux.sv
// Camera-switch output stage: delays main timing/pixels, substitutes minor
// camera pixels from a line FIFO when selected, and assembles the pack bus.
module cam_pack_mux
   import cam_pack_pkg::*;
#(
   parameter int H_ACT = 1280,
   parameter int V_ACT = 720,
   parameter int DELAY = 5,
   parameter int DEPTH = 2048,
   localparam int XW   = $clog2(H_ACT),
   localparam int YW   = $clog2(V_ACT),
   localparam int PW   = pack_w(H_ACT, V_ACT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sel,
   input  logic          m_hsync,
   input  logic          m_vsync,
   input  logic          m_de,
   input  logic [7:0]    m_r,
   input  logic [7:0]    m_g,
   input  logic [7:0]    m_b,
   input  logic [XW-1:0] m_x,
   input  logic [YW-1:0] m_y,
   input  logic          n_we,
   input  logic [23:0]   n_data,
   output logic [PW-1:0] pack,
   output logic          fifo_full,
   output logic          fifo_empty
);

   localparam int STW = CTRL_W - 1 + PIX_W + XW + YW;

   logic [STW-1:0]   stageIn;
   logic [STW-1:0]   stageOut;
   logic             dlyHs, dlyVs, dlyDe;
   logic [PIX_W-1:0] dlyRgb;
   logic [XW-1:0]    dlyX;
   logic [YW-1:0]    dlyY;
   logic             sel_q, sel_d;
   logic             vsync_q;
   logic [PIX_W-1:0] fifoHead;
   logic [PIX_W-1:0] pixRgb;

   assign stageIn = {m_hsync, m_vsync, m_de, m_r, m_g, m_b, m_x, m_y};

   generate
      if (DELAY == 0) begin : g_pass
         assign stageOut = stageIn;
      end else begin : g_dly
         logic [STW-1:0] pipe_q [DELAY];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= stageIn;
               for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign stageOut = pipe_q[DELAY-1];
      end
   endgenerate

   assign {dlyHs, dlyVs, dlyDe, dlyRgb, dlyX, dlyY} = stageOut;

   // Source only switches on the second consecutive vsync-high sample.
   always_comb begin
      sel_d = sel_q;
      if (vsync_q && m_vsync) sel_d = sel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q   <= 1'b1;
         vsync_q <= 1'b0;
      end else begin
         sel_q   <= sel_d;
         vsync_q <= m_vsync;
      end
   end

   line_fifo #(
      .DEPTH (DEPTH),
      .W     (PIX_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (m_vsync),
      .wr_i    (n_we & ~sel_q),
      .wdata_i (n_data),
      .rd_i    (dlyDe & ~sel_q),
      .rdata_o (fifoHead),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // An underflowing minor stream shows up as white rather than stale data.
   always_comb begin
      pixRgb = dlyRgb;
      if (!sel_q) pixRgb = fifo_empty ? 24'hFFFFFF : fifoHead;
   end

   assign pack = {clk, dlyHs, dlyVs, dlyDe, pixRgb, dlyX, dlyY};

endmodule

// File: tb/tb_cam_pack_mux.sv
// Scoreboard bench for cam_pack_mux: expected pack words are queued as de
// stimulus is issued and popped by a monitor whenever the DUT presents de.
module tb_cam_pack_mux;

   localparam int H_ACT = 1280;
   localparam int V_ACT = 720;
   localparam int DELAY = 5;
   localparam int DEPTH = 4;
   localparam int XW    = $clog2(H_ACT);
   localparam int YW    = $clog2(V_ACT);
   localparam int PW    = 28 + XW + YW;
   localparam int LW    = PW - 1;

   typedef struct {
      logic [LW-1:0] data;
      int            due;
      string         name;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          sel;
   logic          m_hsync, m_vsync, m_de;
   logic [7:0]    m_r, m_g, m_b;
   logic [XW-1:0] m_x;
   logic [YW-1:0] m_y;
   logic          n_we;
   logic [23:0]   n_data;
   logic [PW-1:0] pack;
   logic          fifo_full, fifo_empty;

   exp_t          sbQ[$];
   int            total = 0;
   int            bad = 0;
   int            cycleCnt = 0;
   logic [XW-1:0] curX;
   logic [YW-1:0] curY;

   cam_pack_mux #(
      .H_ACT (H_ACT),
      .V_ACT (V_ACT),
      .DELAY (DELAY),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sel        (sel),
      .m_hsync    (m_hsync),
      .m_vsync    (m_vsync),
      .m_de       (m_de),
      .m_r        (m_r),
      .m_g        (m_g),
      .m_b        (m_b),
      .m_x        (m_x),
      .m_y        (m_y),
      .n_we       (n_we),
      .n_data     (n_data),
      .pack       (pack),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One cycle of stimulus, entered just after a negedge and left at the next one.
   task automatic applyStimulus(input logic vs, input logic de, input logic [23:0] rgb,
                                input logic we, input logic [23:0] nd,
                                input logic [23:0] expRgb, input string name);
      exp_t e;
      m_hsync = 1'b0;
      m_vsync = vs;
      m_de    = de;
      {m_r, m_g, m_b} = rgb;
      m_x     = curX;
      m_y     = curY;
      n_we    = we;
      n_data  = nd;
      if (de) begin
         e.data = {1'b0, vs, 1'b1, expRgb, curX, curY};
         e.due  = cycleCnt + DELAY;
         e.name = name;
         sbQ.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 24'h0, "idle");
   endtask

   task automatic vsPair(input logic s);
      sel = s;
      applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 24'h0, 24'h0, "vs");
      applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 24'h0, 24'h0, "vs");
      idle(1);
   endtask

   // Monitor: every de beat on the pack bus consumes one scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && pack[PW-4] === 1'b1) begin
            if (sbQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_de actual=%0h required=no_de", pack[LW-1:0]);
            end else begin
               e = sbQ.pop_front();
               checkOutput({e.name, "_data"}, 64'(pack[LW-1:0]), 64'(e.data));
               checkOutput({e.name, "_latency"}, 64'(cycleCnt), 64'(e.due));
            end
         end
      end
   end

   initial begin
      logic [23:0] base;
      rst = 1'b1; sel = 1'b1;
      m_hsync = 1'b0; m_vsync = 1'b0; m_de = 1'b0;
      m_r = '0; m_g = '0; m_b = '0; m_x = '0; m_y = '0;
      n_we = 1'b0; n_data = '0;
      curX = '0; curY = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset_pack_low", 64'(pack[LW-1:0]), 64'h0);
      checkOutput("reset_empty", 64'(fifo_empty), 64'h1);
      checkOutput("reset_full", 64'(fifo_full), 64'h0);
      @(posedge clk);
      #1;
      checkOutput("pack_clk_bit", 64'(pack[PW-1]), 64'h1);
      @(negedge clk);
      rst = 1'b0;

      // Main pass-through, including the coordinate extremes.
      curX = 11'd10; curY = 10'd3;
      applyStimulus(1'b0, 1'b1, 24'h123456, 1'b0, 24'h0, 24'h123456, "pass");
      idle(6);
      curX = 11'd1279; curY = 10'd719;
      applyStimulus(1'b0, 1'b1, 24'hABCDEF, 1'b0, 24'h0, 24'hABCDEF, "pass_edge");
      idle(6);

      // Minor substitution with underflow to white.
      vsPair(1'b0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 24'hA0 + 24'(i), 24'h0, "wr");
      checkOutput("minor_full", 64'(fifo_full), 64'h1);
      checkOutput("minor_not_empty", 64'(fifo_empty), 64'h0);
      for (int i = 0; i < 5; i++) begin
         curX = 11'(i); curY = 10'd20;
         applyStimulus(1'b0, 1'b1, 24'h111111, 1'b0, 24'h0,
                       (i < 4) ? 24'hA0 + 24'(i) : 24'hFFFFFF, "minor");
      end
      idle(6);
      checkOutput("minor_drained_empty", 64'(fifo_empty), 64'h1);

      // Full/drop behaviour, repeated so the pointers wrap.
      for (int rep = 0; rep < 2; rep++) begin
         base = (rep == 0) ? 24'hB0 : 24'hC0;
         for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, base + 24'(i), 24'h0, "wr");
            if (i == 2) checkOutput("not_full_after3", 64'(fifo_full), 64'h0);
            if (i == 3) checkOutput("full_after4", 64'(fifo_full), 64'h1);
         end
         checkOutput("full_after6", 64'(fifo_full), 64'h1);
         for (int i = 0; i < 5; i++) begin
            curX = 11'(100 + i); curY = 10'(30 + rep);
            applyStimulus(1'b0, 1'b1, 24'h222222, 1'b0, 24'h0,
                          (i < 4) ? base + 24'(i) : 24'hFFFFFF, "wrap");
         end
         idle(6);
         checkOutput("wrap_empty", 64'(fifo_empty), 64'h1);
      end

      // Mid-frame select changes must wait for the next vsync pair.
      sel = 1'b1;
      curX = 11'd5; curY = 10'd40;
      applyStimulus(1'b0, 1'b1, 24'h654321, 1'b0, 24'h0, 24'hFFFFFF, "mid_hold_minor");
      idle(6);
      vsPair(1'b1);
      applyStimulus(1'b0, 1'b1, 24'h654321, 1'b0, 24'h0, 24'h654321, "after_vs_main");
      idle(6);
      sel = 1'b0;
      applyStimulus(1'b0, 1'b1, 24'h0F0F0F, 1'b0, 24'h0, 24'h0F0F0F, "mid_hold_main");
      idle(6);

      // Flush takes priority over a write in the same cycle.
      vsPair(1'b0);
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 24'hD1, 24'h0, "wr");
      checkOutput("pre_flush_not_empty", 64'(fifo_empty), 64'h0);
      applyStimulus(1'b1, 1'b0, 24'h0, 1'b1, 24'hD2, 24'h0, "flush_wr");
      checkOutput("flush_empty", 64'(fifo_empty), 64'h1);
      idle(1);
      curX = 11'd7; curY = 10'd50;
      applyStimulus(1'b0, 1'b1, 24'h444444, 1'b0, 24'h0, 24'hFFFFFF, "flush_lost");
      idle(6);

      // Asynchronous reset mid-frame with data in flight.
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 24'hE0, 24'h0, "wr");
      checkOutput("pre_rst_not_empty", 64'(fifo_empty), 64'h0);
      m_de = 1'b1; {m_r, m_g, m_b} = 24'h555555;
      repeat (2) @(negedge clk);
      m_de = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_empty", 64'(fifo_empty), 64'h1);
      checkOutput("async_rst_pack", 64'(pack[LW-1:0]), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      curX = 11'd9; curY = 10'd60;
      applyStimulus(1'b0, 1'b1, 24'h333333, 1'b0, 24'h0, 24'h333333, "post_reset_main");
      idle(DELAY + 3);

      checkOutput("queue_drained", 64'(sbQ.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
